// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: captures the decoded instruction and presents it to EX one cycle later.
// Update priority at each edge is reset > flush > freeze > load. A flush loads an all-zero bubble,
// so register numbers read as R0 with every enable low and cannot raise a false hazard.
module id_ex_stage_register #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Flush,
  input  logic [DATA_WIDTH-1:0] i_PC,
  input  logic [DATA_WIDTH-1:0] i_Val_Rn,
  input  logic [DATA_WIDTH-1:0] i_Val_Rm,
  input  logic [11:0]           i_Shift_Operand,
  input  logic [23:0]           i_Signed_Imm_24,
  input  logic [3:0]            i_Dest,
  input  logic [3:0]            i_Src_1,
  input  logic [3:0]            i_Src_2,
  input  logic [3:0]            i_Exe_Cmd,
  input  logic                  i_Mem_R_En,
  input  logic                  i_Mem_W_En,
  input  logic                  i_WB_En,
  input  logic                  i_B,
  input  logic                  i_S,
  input  logic                  i_I,
  input  logic [3:0]            i_Status,
  input  logic                  i_Valid,
  output logic [DATA_WIDTH-1:0] o_PC,
  output logic [DATA_WIDTH-1:0] o_Val_Rn,
  output logic [DATA_WIDTH-1:0] o_Val_Rm,
  output logic [11:0]           o_Shift_Operand,
  output logic [23:0]           o_Signed_Imm_24,
  output logic [3:0]            o_Dest,
  output logic [3:0]            o_Src_1,
  output logic [3:0]            o_Src_2,
  output logic [3:0]            o_Exe_Cmd,
  output logic                  o_Mem_R_En,
  output logic                  o_Mem_W_En,
  output logic                  o_WB_En,
  output logic                  o_B,
  output logic                  o_S,
  output logic                  o_I,
  output logic [3:0]            o_Status,
  output logic                  o_Valid
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] val_rn;
    logic [DATA_WIDTH-1:0] val_rm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [3:0]            dest;
    logic [3:0]            src_1;
    logic [3:0]            src_2;
    logic [3:0]            exe_cmd;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  wb_en;
    logic                  b;
    logic                  s;
    logic                  i;
    logic [3:0]            status;
    logic                  valid;
  } stage_t;

  stage_t stage_in;
  stage_t stage_d;
  stage_t stage_q;

  // Gather the decode-stage fields into one record.
  always_comb begin
    stage_in               = '0;
    stage_in.pc            = i_PC;
    stage_in.val_rn        = i_Val_Rn;
    stage_in.val_rm        = i_Val_Rm;
    stage_in.shift_operand = i_Shift_Operand;
    stage_in.signed_imm_24 = i_Signed_Imm_24;
    stage_in.dest          = i_Dest;
    stage_in.src_1         = i_Src_1;
    stage_in.src_2         = i_Src_2;
    stage_in.exe_cmd       = i_Exe_Cmd;
    stage_in.mem_r_en      = i_Mem_R_En;
    stage_in.mem_w_en      = i_Mem_W_En;
    stage_in.wb_en         = i_WB_En;
    stage_in.b             = i_B;
    stage_in.s             = i_S;
    stage_in.i             = i_I;
    stage_in.status        = i_Status;
    stage_in.valid         = i_Valid;
  end

  // Next state: flush inserts a bubble and wins over freeze; freeze holds; otherwise load.
  always_comb begin
    stage_d = stage_q;
    if (i_Flush) begin
      stage_d = '0;
    end else if (!i_Freeze) begin
      stage_d = stage_in;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Outputs come straight from the flops.
  always_comb begin
    o_PC            = stage_q.pc;
    o_Val_Rn        = stage_q.val_rn;
    o_Val_Rm        = stage_q.val_rm;
    o_Shift_Operand = stage_q.shift_operand;
    o_Signed_Imm_24 = stage_q.signed_imm_24;
    o_Dest          = stage_q.dest;
    o_Src_1         = stage_q.src_1;
    o_Src_2         = stage_q.src_2;
    o_Exe_Cmd       = stage_q.exe_cmd;
    o_Mem_R_En      = stage_q.mem_r_en;
    o_Mem_W_En      = stage_q.mem_w_en;
    o_WB_En         = stage_q.wb_en;
    o_B             = stage_q.b;
    o_S             = stage_q.s;
    o_I             = stage_q.i;
    o_Status        = stage_q.status;
    o_Valid         = stage_q.valid;
  end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Scoreboard bench for the ID/EX stage register: the driver queues the hand-written expected
// outputs for each edge, the monitor pops and compares one entry just after every rising edge.
module tb_id_ex_stage_register;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic [11:0]   shift_operand;
    logic [23:0]   signed_imm_24;
    logic [3:0]    dest;
    logic [3:0]    src_1;
    logic [3:0]    src_2;
    logic [3:0]    exe_cmd;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          wb_en;
    logic          b;
    logic          s;
    logic          i;
    logic [3:0]    status;
    logic          valid;
  } fields_t;

  typedef struct {
    fields_t exp;
    string   name;
  } exp_t;

  exp_t    sb_q[$];
  exp_t    cur;
  int      n_cmp  = 0;
  int      n_fail = 0;

  logic    clk = 1'b0;
  logic    reset;
  logic    freeze;
  logic    flush;
  fields_t vin;
  fields_t vout;

  // Register-file model: write on the falling edge, combinational read.
  logic          use_rf;
  logic          rf_we;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] rf2;
  logic [DW-1:0] val_rn_drv;

  assign val_rn_drv = use_rf ? rf2 : vin.val_rn;

  always #5 clk = ~clk;

  initial begin
    rf2 = '0;
    forever begin
      @(negedge clk);
      if (rf_we) rf2 = rf_wd;
    end
  end

  logic [DW-1:0] o_pc, o_val_rn, o_val_rm;
  logic [11:0]   o_shift_operand;
  logic [23:0]   o_signed_imm_24;
  logic [3:0]    o_dest, o_src_1, o_src_2, o_exe_cmd, o_status;
  logic          o_mem_r_en, o_mem_w_en, o_wb_en, o_b, o_s, o_i, o_valid;

  assign vout = '{pc: o_pc, val_rn: o_val_rn, val_rm: o_val_rm, shift_operand: o_shift_operand,
                  signed_imm_24: o_signed_imm_24, dest: o_dest, src_1: o_src_1, src_2: o_src_2,
                  exe_cmd: o_exe_cmd, mem_r_en: o_mem_r_en, mem_w_en: o_mem_w_en,
                  wb_en: o_wb_en, b: o_b, s: o_s, i: o_i, status: o_status, valid: o_valid};

  id_ex_stage_register #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_Freeze        (freeze),
    .i_Flush         (flush),
    .i_PC            (vin.pc),
    .i_Val_Rn        (val_rn_drv),
    .i_Val_Rm        (vin.val_rm),
    .i_Shift_Operand (vin.shift_operand),
    .i_Signed_Imm_24 (vin.signed_imm_24),
    .i_Dest          (vin.dest),
    .i_Src_1         (vin.src_1),
    .i_Src_2         (vin.src_2),
    .i_Exe_Cmd       (vin.exe_cmd),
    .i_Mem_R_En      (vin.mem_r_en),
    .i_Mem_W_En      (vin.mem_w_en),
    .i_WB_En         (vin.wb_en),
    .i_B             (vin.b),
    .i_S             (vin.s),
    .i_I             (vin.i),
    .i_Status        (vin.status),
    .i_Valid         (vin.valid),
    .o_PC            (o_pc),
    .o_Val_Rn        (o_val_rn),
    .o_Val_Rm        (o_val_rm),
    .o_Shift_Operand (o_shift_operand),
    .o_Signed_Imm_24 (o_signed_imm_24),
    .o_Dest          (o_dest),
    .o_Src_1         (o_src_1),
    .o_Src_2         (o_src_2),
    .o_Exe_Cmd       (o_exe_cmd),
    .o_Mem_R_En      (o_mem_r_en),
    .o_Mem_W_En      (o_mem_w_en),
    .o_WB_En         (o_wb_en),
    .o_B             (o_b),
    .o_S             (o_s),
    .o_I             (o_i),
    .o_Status        (o_status),
    .o_Valid         (o_valid)
  );

  // Monitor: each edge's expectation is checked 1 time unit after that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        n_cmp++;
        if (vout !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", cur.name, vout, cur.exp);
        end
      end
    end
  end

  // Drive one vector after an edge and queue what the outputs must be after the next edge.
  task automatic step(input string name, input logic rst, input logic frz, input logic fl,
                      input logic rf_mode, input fields_t v, input fields_t exp);
    @(posedge clk);
    #2;
    reset  = rst;
    freeze = frz;
    flush  = fl;
    vin    = v;
    use_rf = rf_mode;
    rf_we  = rf_mode;
    sb_q.push_back('{exp: exp, name: name});
  endtask

  fields_t z, a, n, ia, ib, f, inv, w, wexp;

  initial begin
    reset  = 1'b1;
    freeze = 1'b0;
    flush  = 1'b0;
    vin    = '0;
    use_rf = 1'b0;
    rf_we  = 1'b0;
    rf_wd  = 32'h0000_1234;
    repeat (2) @(posedge clk);

    z = '0;

    a = '{pc: 32'hCAFE_0004, val_rn: 32'hDEAD_BEEF, val_rm: 32'h0BAD_F00D,
          shift_operand: 12'hABC, signed_imm_24: 24'h80_1234, dest: 4'hE, src_1: 4'hD,
          src_2: 4'hC, exe_cmd: 4'hB, mem_r_en: 1'b1, mem_w_en: 1'b1, wb_en: 1'b1, b: 1'b1,
          s: 1'b1, i: 1'b1, status: 4'hF, valid: 1'b1};

    n = z;
    n.pc = 32'h0000_0010; n.val_rn = 32'd5; n.val_rm = 32'd7; n.dest = 4'd3;
    n.exe_cmd = 4'b0010; n.wb_en = 1'b1; n.valid = 1'b1;

    ia = z;
    ia.pc = 32'h0000_0100; ia.val_rn = 32'h1111_1111; ia.val_rm = 32'h2222_2222;
    ia.shift_operand = 12'h0F3; ia.dest = 4'd1; ia.src_1 = 4'd2; ia.src_2 = 4'd3;
    ia.exe_cmd = 4'b0100; ia.wb_en = 1'b1; ia.s = 1'b1; ia.status = 4'b1000; ia.valid = 1'b1;

    ib = z;
    ib.pc = 32'h0000_0104; ib.val_rn = 32'h3333_3333; ib.val_rm = 32'h4444_4444;
    ib.signed_imm_24 = 24'hFF_FFFE; ib.dest = 4'd5; ib.src_1 = 4'd6; ib.src_2 = 4'd7;
    ib.exe_cmd = 4'b1001; ib.mem_r_en = 1'b1; ib.wb_en = 1'b1; ib.i = 1'b1;
    ib.status = 4'b0110; ib.valid = 1'b1;

    f = ib;
    f.wb_en = 1'b1; f.mem_w_en = 1'b1; f.dest = 4'd9;

    inv = ia;
    inv.valid = 1'b0;

    w = z;
    w.pc = 32'h0000_0200; w.src_1 = 4'd2; w.dest = 4'd4; w.wb_en = 1'b1; w.valid = 1'b1;
    w.val_rn = 32'hFFFF_FFFF;
    wexp = w;
    wexp.val_rn = 32'h0000_1234;

    step("reset_with_inputs", 1'b1, 1'b0, 1'b0, 1'b0, a,   z);
    step("preload",           1'b0, 1'b0, 1'b0, 1'b0, a,   a);
    step("reset_while_frozen",1'b1, 1'b1, 1'b0, 1'b0, a,   z);
    step("normal_load",       1'b0, 1'b0, 1'b0, 1'b0, n,   n);
    step("load_a",            1'b0, 1'b0, 1'b0, 1'b0, ia,  ia);
    step("freeze_1",          1'b0, 1'b1, 1'b0, 1'b0, ib,  ia);
    step("freeze_2",          1'b0, 1'b1, 1'b0, 1'b0, ib,  ia);
    step("freeze_3",          1'b0, 1'b1, 1'b0, 1'b0, ib,  ia);
    step("release_b",         1'b0, 1'b0, 1'b0, 1'b0, ib,  ib);
    step("flush",             1'b0, 1'b0, 1'b1, 1'b0, f,   z);
    step("reload_a",          1'b0, 1'b0, 1'b0, 1'b0, ia,  ia);
    step("flush_and_freeze",  1'b0, 1'b1, 1'b1, 1'b0, ia,  z);
    step("reload_a_again",    1'b0, 1'b0, 1'b0, 1'b0, ia,  ia);
    step("flush_cycle_1",     1'b0, 1'b0, 1'b1, 1'b0, ib,  z);
    step("flush_cycle_2",     1'b0, 1'b0, 1'b1, 1'b0, ib,  z);
    step("invalid_load",      1'b0, 1'b0, 1'b0, 1'b0, inv, inv);
    step("preload_again",     1'b0, 1'b0, 1'b0, 1'b0, a,   a);
    step("reset_mid_flush",   1'b1, 1'b1, 1'b1, 1'b0, a,   z);
    step("wb_freshness",      1'b0, 1'b0, 1'b0, 1'b1, w,   wexp);
    step("after_freshness",   1'b0, 1'b0, 1'b0, 1'b0, ib,  ib);

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb_q.size());
    end
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

ID/EX pipeline register of the five-stage ARM core. It captures the decoded instruction from the decode stage: the two register-file operand values, the immediate fields, destination and source register numbers, control signals and the current status flags. It presents them to the execute stage one cycle later. Stall (freeze) and branch-flush control come from the hazard unit and the execute stage.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC and operand values

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state at the next rising edge
- i_Freeze  input  1  hazard stall; hold every stored field
- i_Flush  input  1  branch taken in EX; squash the instruction being captured
- i_PC  input  DATA_WIDTH  PC+4 of the decoded instruction
- i_Val_Rn  input  DATA_WIDTH  first operand read from the register file
- i_Val_Rm  input  DATA_WIDTH  second operand read from the register file
- i_Shift_Operand  input  12  instruction bits [11:0]
- i_Signed_Imm_24  input  24  branch offset, instruction bits [23:0]
- i_Dest  input  4  destination register number
- i_Src_1  input  4  Rn number, forwarded to the hazard logic
- i_Src_2  input  4  Rm/Rd number, forwarded to the hazard logic
- i_Exe_Cmd  input  4  ALU command
- i_Mem_R_En, i_Mem_W_En, i_WB_En  input  1 each  memory-read, memory-write and write-back enables
- i_B, i_S, i_I  input  1 each  branch, set-flags and immediate-operand flags
- i_Status  input  4  NZCV from the status register
- i_Valid  input  1  decode stage holds a real instruction
- o_* outputs  output  same widths  registered copies of every i_* field above, excluding i_Freeze and i_Flush
- o_Valid  output  1  EX stage holds a real instruction

## Operation
- Update priority at each rising edge of clk: reset > flush > freeze > load.
- reset: every output goes to 0, including o_Valid, o_PC, all data fields and all control bits.
- Flush (i_Flush=1): load a bubble.
  - Control outputs cleared: o_WB_En, o_Mem_R_En, o_Mem_W_En, o_B, o_S, o_Valid, o_Exe_Cmd.
  - Data fields and register numbers also cleared to 0, so no false hazard matches on R0 with o_WB_En=0.
  - Flush wins over freeze when both are asserted in the same cycle.
- Freeze (i_Freeze=1, i_Flush=0): all outputs hold their previous values.
- Load (neither asserted): every o_* field takes the matching i_* value.
- o_Valid follows i_Valid on load. A loaded instruction with i_Valid=0 still copies its fields, but downstream stages must ignore it.
- No arithmetic is performed. Fields pass through at full width, with no sign extension; that happens in EX.
- Operand freshness:
  - The register file commits write-back on the falling edge, and its read is combinational.
  - The value sampled here at the rising edge already reflects a write-back from the same cycle.
  - No internal bypass is required.

## Timing
- Latency is 1 cycle from input to output on load.
- Freeze holds indefinitely. The release cycle loads whatever inputs are present at that edge, and the upstream stage must present the held instruction.
- Flush takes effect at the edge where it is sampled. It is a single-cycle pulse; a multi-cycle assertion inserts one bubble per cycle.
- A reset asserted mid-stall or mid-flush clears the state at the next edge, regardless of i_Freeze and i_Flush.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- Reset:
  - Stimulus: preload all fields with nonzero values (o_Val_Rn=32'hDEADBEEF, o_WB_En=1), then assert reset for 1 cycle with i_Freeze=1.
  - Required response: all outputs 0 after the edge.
- Normal load:
  - Stimulus: i_PC=32'h0000_0010, i_Val_Rn=5, i_Val_Rm=7, i_Dest=4'd3, i_Exe_Cmd=4'b0010, i_WB_En=1, i_Valid=1.
  - Required response: identical values on the outputs exactly one cycle later.
- Freeze:
  - Stimulus: load instruction A, then assert i_Freeze for 3 cycles while the inputs change to instruction B.
  - Required response: outputs stay at A for all 3 cycles, then show B one edge after release.
- Flush:
  - Stimulus: load with i_WB_En=1, i_Mem_W_En=1, i_Dest=4'd9, i_Flush=1.
  - Required response: after the edge, o_WB_En=0, o_Mem_W_En=0, o_Dest=0, o_Valid=0, o_Val_Rn=0.
- Flush plus freeze:
  - Stimulus: assert i_Flush and i_Freeze together while holding a valid instruction.
  - Required response: a bubble is loaded with o_Valid=0; the held instruction is not kept.
- Write-back freshness:
  - Stimulus: the register file writes R2=32'h1234 on the falling edge, and decode reads R2 in the same cycle.
  - Required response: o_Val_Rn=32'h1234 after the next rising edge.
